// File: rtl/aes_pkg.sv
// Shared AES-128 decrypt definitions: round count, Rcon, GF(2^8) helpers,
// InvMixColumns / InvShiftRows on the column-major 128-bit state and the FSM enum.
package aes_pkg;

  localparam int NR = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_e;

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul9(input logic [7:0] b);
    logic [7:0] b2, b4, b8;
    b2 = xtime(b); b4 = xtime(b2); b8 = xtime(b4);
    return b8 ^ b;
  endfunction

  function automatic logic [7:0] gmulb(input logic [7:0] b);
    logic [7:0] b2, b4, b8;
    b2 = xtime(b); b4 = xtime(b2); b8 = xtime(b4);
    return b8 ^ b2 ^ b;
  endfunction

  function automatic logic [7:0] gmuld(input logic [7:0] b);
    logic [7:0] b2, b4, b8;
    b2 = xtime(b); b4 = xtime(b2); b8 = xtime(b4);
    return b8 ^ b4 ^ b;
  endfunction

  function automatic logic [7:0] gmule(input logic [7:0] b);
    logic [7:0] b2, b4, b8;
    b2 = xtime(b); b4 = xtime(b2); b8 = xtime(b4);
    return b8 ^ b4 ^ b2;
  endfunction

  // One column, s0 in [31:24]
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
    return {gmule(a0) ^ gmulb(a1) ^ gmuld(a2) ^ gmul9(a3),
            gmul9(a0) ^ gmule(a1) ^ gmulb(a2) ^ gmuld(a3),
            gmuld(a0) ^ gmul9(a1) ^ gmule(a2) ^ gmulb(a3),
            gmulb(a0) ^ gmuld(a1) ^ gmul9(a2) ^ gmule(a3)};
  endfunction

  // out[r][c] = in[r][(c - r) mod 4]; byte (r,c) sits at index 4c+r from the MSB
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Inverse AES S-box, combinational lookup; one per state byte on the round datapath.
module aes_inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] d
);

  localparam logic [2047:0] T = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  assign d = T[{~a, 3'b000} +: 8];

endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box, combinational lookup; used for SubWord in the key step.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] d
);

  localparam logic [2047:0] T = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // entry 0 is the most significant byte
  assign d = T[{~a, 3'b000} +: 8];

endmodule

// File: rtl/aes_dec_iter128.sv
// Iterative AES-128 decryptor: one inverse round per clock, round keys
// rolled backwards on the fly starting from the round-10 key.
module aes_dec_iter128
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ct,
  input  logic [127:0] key_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] pt
);

  fsm_e         state, state_nx;
  logic [127:0] st, rk, rk_nx;
  logic [127:0] sr, sb, ark, imc;
  logic [3:0]   rnd;
  logic         last;
  logic [31:0]  w0, w1, w2, w3, n0, n1, n2, n3, rot, sub;

  assign in_ready = (state == IDLE);
  assign last     = (rnd == 4'd0);

  // Key step: rk_{i-1} from rk_i
  assign {w0, w1, w2, w3} = rk;
  assign n3  = w3 ^ w2;
  assign n2  = w2 ^ w1;
  assign n1  = w1 ^ w0;
  assign rot = {n3[23:0], n3[31:24]};

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_ksb
      aes_sbox u_sb (.a(rot[8*g +: 8]), .d(sub[8*g +: 8]));
    end
  endgenerate

  assign n0    = w0 ^ sub ^ {rcon(rnd + 4'd1), 24'h0};
  assign rk_nx = {n0, n1, n2, n3};

  // Data step
  assign sr = inv_shift_rows(st);

  generate
    for (g = 0; g < 16; g++) begin : g_isb
      aes_inv_sbox u_isb (.a(sr[8*g +: 8]), .d(sb[8*g +: 8]));
    end
  endgenerate

  assign ark = sb ^ rk_nx;

  generate
    for (g = 0; g < 4; g++) begin : g_imc
      assign imc[32*g +: 32] = inv_mix_col(ark[32*g +: 32]);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = BUSY;
      BUSY:    if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= '0;
      rk        <= '0;
      rnd       <= '0;
      pt        <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          st  <= ct ^ key_last;
          rk  <= key_last;
          rnd <= 4'(NR - 1);
        end
        BUSY: begin
          rk <= rk_nx;
          // final round skips InvMixColumns and lands straight in pt
          if (last) begin
            pt        <= ark;
            out_valid <= 1'b1;
          end else begin
            st  <= imc;
            rnd <= rnd - 4'd1;
          end
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
